adc_i2s_receiver: RTL and testbench
===================================

Name: adc_i2s_receiver

Overview:
- Capture side of the codec serial audio link: deserialises AUD_ADCDAT (I2S format, codec is bit-clock/LRCK master) into parallel 16-bit left/right samples in the Clk domain.
- It is the counterpart of the existing DAC serialiser path: that path writes LDATA/RDATA out, this block reads samples in.
- Delivers one stereo frame per LRCK period to downstream logic (NCO modulation, metering, NIOS PIO) over a valid/ready handshake with sticky overrun reporting.

Parameters:
DATA_WIDTH, 16, bits per channel word delivered; MSB first on the wire.
BIT_DELAY, 1, BCLK rising edges skipped after each LRCK transition before the MSB (1 = I2S, 0 = left-justified).
LEFT_LEVEL, 0, ADCLRCK level that denotes the left channel.

Ports:
Clk  in  1  system clock (CLOCK_50); must exceed 4x BCLK.
Reset_n  in  1  asynchronous, active-low reset.
Enable  in  1  capture enable; low forces re-sync.
AUD_BCLK  in  1  codec bit clock; asynchronous to Clk.
AUD_ADCLRCK  in  1  codec ADC word clock; asynchronous.
AUD_ADCDAT  in  1  codec serial ADC data; asynchronous.
LDATA  out  DATA_WIDTH  left sample of the held frame.
RDATA  out  DATA_WIDTH  right sample of the held frame.
Valid  out  1  frame held in LDATA/RDATA.
Ready  in  1  consumer accepts the frame when Valid & Ready.
Overrun  out  1  sticky: a completed frame was dropped.
Clear_overrun  in  1  synchronous clear of Overrun.

Behaviour:
- Reset (async assert, sync release): LDATA=0, RDATA=0, Valid=0, Overrun=0, FSM=SYNC, bit counter=0, shift register=0.
- Input synchronisation:
  - BCLK, ADCLRCK and ADCDAT each pass through 2 flops, plus a 3rd flop on BCLK and LRCK for edge detection.
  - bclk_rise = sync2 & ~sync3.
  - All capture logic acts only on Clk cycles where bclk_rise=1.
  - LRCK is sampled on bclk_rise, so an LRCK transition is recognised at the first bclk_rise after it.
- FSM, evaluated on bclk_rise only:
  - SYNC: wait for an LRCK transition into the LEFT_LEVEL state. Partial frames after reset or Enable rise are discarded. Then go to SKIP with chan=L and skip counter=BIT_DELAY.
  - SKIP: skip BIT_DELAY bclk_rise events, including the one that detected the edge. If BIT_DELAY=0, the detecting edge itself captures the MSB (go directly to SHIFT behaviour).
  - SHIFT: shift ADCDAT into the LSB of the shift register and increment the counter.
    - When count reaches DATA_WIDTH, the word is complete: load into the L or R holding register and go to WAIT.
    - Bits beyond DATA_WIDTH are ignored.
  - WAIT: wait for the next LRCK transition; then chan toggles and the FSM returns to SKIP.
  - Early LRCK transition while in SKIP/SHIFT (short word): the word is finalised immediately, left-aligned with unreceived LSBs zero-filled. The FSM then proceeds as for a normal transition.
- Frame completion and handshake:
  - A frame completes when the right word completes.
  - If Valid=0, or Valid & Ready in the same cycle: on the next Clk, LDATA/RDATA get the new pair and Valid=1. Latency is 1 Clk after the completing bclk_rise cycle.
  - If Valid=1 & Ready=0: the new frame is dropped, held data is unchanged, and Overrun=1 on the next Clk.
  - Valid & Ready with no completing frame: Valid=0 next Clk. LDATA/RDATA hold their last values.
  - LDATA/RDATA are stable whenever Valid=1.
- Overrun:
  - Set dominates Clear_overrun in the same cycle.
  - Cleared only by Clear_overrun or reset.
- Enable:
  - Enable=0: FSM forced to SYNC and the partial word is discarded.
  - Valid, held data and Overrun are unaffected by Enable, so a pending frame can still be consumed.
- Reset mid-word: all state clears immediately. After release, the block resynchronises on the next left-channel LRCK edge.
- Arithmetic: the bit counter is ceil(log2(DATA_WIDTH+1)) bits, saturating at DATA_WIDTH. Data is two's complement and is passed unchanged.

Test Plan:
- Bench setup: Clk 50 MHz, BCLK=Clk/16, 32 BCLK per LRCK half, I2S.
- Basic frame: after reset, send L=0x8001, R=0x7FFE with Ready=1 -> Valid pulses once per frame; LDATA=0x8001, RDATA=0x7FFE; Valid rises 1 Clk after the 16th right-bit bclk_rise.
- Mid-frame start: release reset halfway through a left word (L=0x1234, R=0x5678), then a full frame L=0xAAAA, R=0x5555 -> the first Valid carries 0xAAAA/0x5555; the partial frame is never presented.
- Back-pressure: hold Ready=0 across 3 frames (0x0001/0x0002, 0x0003/0x0004, 0x0005/0x0006) -> data stays 0x0001/0x0002 and Overrun=1. Then Ready=1 for one cycle -> Valid=0. Clear_overrun -> Overrun=0. Also pulse Clear_overrun on the exact cycle a drop occurs -> Overrun stays 1.
- Short word: shorten the LRCK half to 10 BCLK, left word bits 1011001110 -> LDATA=0xB380 (zero-filled). With 24-bit words on a 32-BCLK half, sending 0xABCDEF -> LDATA=0xABCD.
- Left-justified mode: BIT_DELAY=0, L=0xC3C3, R=0x3C3C -> captured exactly. The same stimulus with BIT_DELAY=1 yields 1-bit-shifted values (checked).
- Enable/reset mid-word: drop Enable for 5 Clk during a right word -> no frame delivered for that LRCK period; capture resumes at the next left edge. Assert Reset_n low asynchronously between Clk edges -> all outputs are 0 immediately.

Source files
------------

// File: rtl/adc_i2s_receiver.sv
`timescale 1ns/1ps
// I2S/left-justified ADC deserialiser: async codec pins -> one stereo frame per LRCK period.
// Frame is presented 1 Clk after its completing BCLK edge; a frame arriving while one is still held unconsumed is dropped and sets sticky Overrun.
module adc_i2s_receiver #(
    parameter int   DATA_WIDTH = 16,
    parameter int   BIT_DELAY  = 1,
    parameter logic LEFT_LEVEL = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] LDATA,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  Valid,
    input  logic                  Ready,
    output logic                  Overrun,
    input  logic                  Clear_overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int SW = (BIT_DELAY > 1) ? $clog2(BIT_DELAY) : 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DATA_WIDTH);
    localparam logic [SW-1:0] SKIP_INIT = SW'((BIT_DELAY > 0) ? BIT_DELAY - 1 : 0);

    typedef enum logic [1:0] {S_SYNC, S_SKIP, S_SHIFT, S_WAIT} state_t;

    logic [2:0]            r_bclk_s;
    logic [1:0]            r_lrck_s;
    logic [1:0]            r_dat_s;
    logic                  r_lrck_q;
    logic                  r_lrck_ok;
    state_t                r_state;
    logic                  r_chan;
    logic [SW-1:0]         r_skip;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_lword;
    logic [DATA_WIDTH-1:0] r_ldata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_overrun;

    logic                  w_bclk_rise;
    logic                  w_lrck;
    logic                  w_edge;
    logic                  w_capture;
    logic [CW-1:0]         w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_shift_in;
    logic [DATA_WIDTH-1:0] w_aligned;
    logic                  w_word_done;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_frame_done;

    assign w_bclk_rise = r_bclk_s[1] & ~r_bclk_s[2];
    assign w_lrck      = r_lrck_s[1];
    // r_lrck_ok masks the bogus "edge" against the reset value of r_lrck_q
    assign w_edge      = w_bclk_rise & r_lrck_ok & (w_lrck != r_lrck_q);
    assign w_capture   = (r_state == S_SHIFT) || ((r_state == S_SKIP) && (r_skip == '0));
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_shift_in  = {r_shift[DATA_WIDTH-2:0], r_dat_s[1]};
    assign w_aligned   = r_shift << (CNT_FULL - r_cnt);

    always_comb begin
        w_word_done = 1'b0;
        w_word      = '0;
        if (Enable && w_bclk_rise) begin
            if (w_edge && ((r_state == S_SKIP) || (r_state == S_SHIFT))) begin
                w_word_done = 1'b1;
                w_word      = w_aligned;
            end else if (!w_edge && w_capture && (w_cnt_inc == CNT_FULL)) begin
                w_word_done = 1'b1;
                w_word      = w_shift_in;
            end
        end
    end

    assign w_frame_done = w_word_done & r_chan;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bclk_s  <= '0;
            r_lrck_s  <= '0;
            r_dat_s   <= '0;
            r_lrck_q  <= 1'b0;
            r_lrck_ok <= 1'b0;
            r_state   <= S_SYNC;
            r_chan    <= 1'b0;
            r_skip    <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_lword   <= '0;
        end else begin
            r_bclk_s <= {r_bclk_s[1:0], AUD_BCLK};
            r_lrck_s <= {r_lrck_s[0], AUD_ADCLRCK};
            r_dat_s  <= {r_dat_s[0], AUD_ADCDAT};
            if (w_bclk_rise) begin
                r_lrck_q  <= w_lrck;
                r_lrck_ok <= 1'b1;
            end
            if (!Enable) begin
                r_state <= S_SYNC;
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_bclk_rise) begin
                if (w_word_done && !r_chan)
                    r_lword <= w_word;
                if (w_edge && ((r_state != S_SYNC) || (w_lrck == LEFT_LEVEL))) begin
                    r_chan <= (r_state == S_SYNC) ? 1'b0 : ~r_chan;
                    if (BIT_DELAY == 0) begin
                        r_state <= S_SHIFT;
                        r_shift <= {{(DATA_WIDTH-1){1'b0}}, r_dat_s[1]};
                        r_cnt   <= CW'(1);
                    end else begin
                        r_state <= S_SKIP;
                        r_skip  <= SKIP_INIT;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end else if ((r_state == S_SKIP) && (r_skip != '0)) begin
                    r_skip <= r_skip - SW'(1);
                end else if (w_capture) begin
                    r_shift <= w_shift_in;
                    r_cnt   <= w_cnt_inc;
                    r_state <= (w_cnt_inc == CNT_FULL) ? S_WAIT : S_SHIFT;
                end
            end
        end
    end

    // Held pair only changes when the consumer has taken (or never had) the previous one
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ldata   <= '0;
            r_rdata   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_done) begin
                if (!r_valid || Ready) begin
                    r_ldata <= r_lword;
                    r_rdata <= w_word;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && Ready) begin
                r_valid <= 1'b0;
            end
            if (w_frame_done && r_valid && !Ready)
                r_overrun <= 1'b1;
            else if (Clear_overrun)
                r_overrun <= 1'b0;
        end
    end

    assign LDATA   = r_ldata;
    assign RDATA   = r_rdata;
    assign Valid   = r_valid;
    assign Overrun = r_overrun;

endmodule

// File: tb/tb_adc_i2s_receiver.sv
`timescale 1ns/1ps
// Bench for adc_i2s_receiver: codec-side bit stream driven from Clk, frames scored against expected tables and a slot-level model.
module tb_adc_i2s_receiver;

    localparam int W = 16;

    typedef struct {
        logic [31:0] l_bits;
        int          l_n;
        int          l_slots;
        logic [31:0] r_bits;
        int          r_n;
        int          r_slots;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b1;
    logic         bclk = 1'b1;
    logic         lrck = 1'b1;
    logic         adcdat = 1'b0;
    logic         ready = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] ldata, rdata, lj_ldata, lj_rdata;
    logic         valid, overrun, lj_valid, lj_overrun;

    int           errors = 0;
    int           checks = 0;
    int           rise_cnt = 0;
    int           rx_cnt = 0;
    bit           mon_en = 1'b0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_e;

    always #10 clk = ~clk;

    adc_i2s_receiver #(.DATA_WIDTH(W), .BIT_DELAY(1), .LEFT_LEVEL(1'b0)) u_dut (
        .Clk(clk), .Reset_n(rst_n), .Enable(enable),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat),
        .LDATA(ldata), .RDATA(rdata), .Valid(valid), .Ready(ready),
        .Overrun(overrun), .Clear_overrun(clr)
    );

    adc_i2s_receiver #(.DATA_WIDTH(W), .BIT_DELAY(0), .LEFT_LEVEL(1'b0)) u_lj (
        .Clk(clk), .Reset_n(rst_n), .Enable(enable),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat),
        .LDATA(lj_ldata), .RDATA(lj_rdata), .Valid(lj_valid), .Ready(ready),
        .Overrun(lj_overrun), .Clear_overrun(clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One BCLK period: data and LRCK change on the falling edge, 8 Clk low then 8 Clk high
    task automatic slot(input logic lr, input logic d);
        @(negedge clk);
        bclk   = 1'b0;
        lrck   = lr;
        adcdat = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        rise_cnt++;
        repeat (7) @(negedge clk);
    endtask

    task automatic send_raw(input logic lr, input logic [31:0] pat, input int slots);
        for (int i = 0; i < slots; i++) slot(lr, pat[31-i]);
    endtask

    function automatic logic [31:0] place(input logic [31:0] bits, input int n, input int off);
        return (bits << (32 - n)) >> off;
    endfunction

    task automatic send_word(input logic lr, input logic [31:0] bits, input int n,
                             input int slots, input int off);
        send_raw(lr, place(bits, n, off), slots);
    endtask

    // Word a receiver with bit delay bd must deliver from one LRCK half of the given slot pattern
    function automatic logic [W-1:0] model_word(input logic [31:0] pat, input int slots, input int bd);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < W; k++)
            if (bd + k < slots) w[W-1-k] = pat[31-bd-k];
        return w;
    endfunction

    task automatic wait_rise(input int target);
        int k;
        k = 0;
        while (rise_cnt < target && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (rise_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_rise: reached %0d rises, required %0d", rise_cnt, target);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && valid && ready) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame: got L=%h R=%h, required no frame", ldata, rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ldata, rdata} !== mon_e) begin
                    errors++;
                    $display("FAIL frame: got L=%h R=%h required L=%h R=%h",
                             ldata, rdata, mon_e[2*W-1:W], mon_e[W-1:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   base;
        int   rx0;
        logic [31:0] lp, rp;
        int   ls, rs;

        vecs[0] = '{32'h8001,   16, 32, 32'h7FFE,   16, 32, 16'h8001, 16'h7FFE};
        vecs[1] = '{32'h2CE,    10, 11, 32'h1357,   16, 32, 16'hB380, 16'h1357};
        vecs[2] = '{32'hABCDEF, 24, 32, 32'h123456, 24, 32, 16'hABCD, 16'h1234};
        vecs[3] = '{32'h4321,   16, 32, 32'hFFFF,   16, 12, 16'h4321, 16'hFFE0};
        vecs[4] = '{32'hFFFF,   16,  9, 32'h8000,   16, 17, 16'hFF00, 16'h8000};

        // Reset state
        #5 rst_n = 1'b0;
        idle(4);
        check("rst_ldata", ldata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        send_raw(1'b1, 32'h0, 4);
        mon_en = 1'b1;

        // Table of frames: full, short, over-long and exactly-full words
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back({vecs[v].exp_l, vecs[v].exp_r});
            send_word(1'b0, vecs[v].l_bits, vecs[v].l_n, vecs[v].l_slots, 1);
            send_word(1'b1, vecs[v].r_bits, vecs[v].r_n, vecs[v].r_slots, 1);
        end
        idle(20);
        check("table_pending", exp_q.size(), 0);

        // Latency: Valid rises on the Clk after the bclk_rise cycle of the 16th right bit
        exp_q.push_back({16'h8001, 16'h7FFE});
        send_word(1'b0, 32'h8001, 16, 32, 1);
        base = rise_cnt;
        fork
            send_word(1'b1, 32'h7FFE, 16, 32, 1);
            begin
                wait_rise(base + 17);
                repeat (2) @(negedge clk);
                check("lat_valid_early", valid, 0);
                @(negedge clk);
                check("lat_valid_rise", valid, 1);
                check("lat_ldata", ldata, 16'h8001);
                check("lat_rdata", rdata, 16'h7FFE);
                @(negedge clk);
                check("lat_valid_pulse", valid, 0);
            end
        join

        // Left-justified stimulus: BIT_DELAY=0 exact, BIT_DELAY=1 one bit shifted
        exp_q.push_back({16'h8786, 16'h7878});
        send_word(1'b0, 32'hC3C3, 16, 32, 0);
        send_word(1'b1, 32'h3C3C, 16, 32, 0);
        idle(10);
        check("lj_ldata", lj_ldata, 16'hC3C3);
        check("lj_rdata", lj_rdata, 16'h3C3C);
        check("lj_pending", exp_q.size(), 0);

        // Random slot patterns and half lengths against the model
        for (int f = 0; f < 8; f++) begin
            lp = $urandom;
            rp = $urandom;
            ls = $urandom_range(32, 12);
            rs = (f == 7) ? 32 : $urandom_range(32, 12);
            exp_q.push_back({model_word(lp, ls, 1), model_word(rp, rs, 1)});
            send_raw(1'b0, lp, ls);
            send_raw(1'b1, rp, rs);
        end
        idle(20);
        check("rand_pending", exp_q.size(), 0);

        // Back-pressure and overrun
        mon_en = 1'b0;
        ready  = 1'b0;
        send_word(1'b0, 32'h0001, 16, 32, 1); send_word(1'b1, 32'h0002, 16, 32, 1);
        send_word(1'b0, 32'h0003, 16, 32, 1); send_word(1'b1, 32'h0004, 16, 32, 1);
        send_word(1'b0, 32'h0005, 16, 32, 1); send_word(1'b1, 32'h0006, 16, 32, 1);
        idle(10);
        check("bp_valid", valid, 1);
        check("bp_ldata", ldata, 16'h0001);
        check("bp_rdata", rdata, 16'h0002);
        check("bp_overrun", overrun, 1);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check("bp_consumed", valid, 0);
        check("bp_hold_l", ldata, 16'h0001);
        check("bp_hold_r", rdata, 16'h0002);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        send_word(1'b0, 32'h0007, 16, 32, 1);
        send_word(1'b1, 32'h0008, 16, 32, 1);
        idle(5);
        check("hold_valid", valid, 1);
        send_word(1'b0, 32'h0009, 16, 32, 1);
        base = rise_cnt;
        fork
            send_word(1'b1, 32'h000A, 16, 32, 1);
            begin
                wait_rise(base + 17);
                repeat (2) @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                check("ovr_set_wins", overrun, 1);
            end
        join
        check("drop_keep_l", ldata, 16'h0007);
        check("drop_keep_r", rdata, 16'h0008);

        // Async reset mid-word, released halfway into a left word
        exp_q.push_back({16'hAAAA, 16'h5555});
        base = rise_cnt;
        fork
            begin
                send_word(1'b0, 32'h1234, 16, 32, 1); send_word(1'b1, 32'h5678, 16, 32, 1);
                send_word(1'b0, 32'hAAAA, 16, 32, 1); send_word(1'b1, 32'h5555, 16, 32, 1);
            end
            begin
                wait_rise(base + 4);
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("arst_ldata", ldata, 0);
                check("arst_rdata", rdata, 0);
                check("arst_valid", valid, 0);
                check("arst_overrun", overrun, 0);
                check("arst_lj_flags", {lj_valid, lj_overrun}, 0);
                ready  = 1'b1;
                mon_en = 1'b1;
                wait_rise(base + 9);
                @(negedge clk) rst_n = 1'b1;
            end
        join
        idle(20);
        check("midstart_pending", exp_q.size(), 0);

        // Enable dropped for 5 Clk during a right word
        rx0 = rx_cnt;
        exp_q.push_back({16'h3333, 16'h4444});
        send_word(1'b0, 32'h1111, 16, 32, 1);
        base = rise_cnt;
        fork
            send_word(1'b1, 32'h2222, 16, 32, 1);
            begin
                wait_rise(base + 8);
                @(negedge clk) enable = 1'b0;
                repeat (5) @(negedge clk);
                enable = 1'b1;
            end
        join
        send_word(1'b0, 32'h3333, 16, 32, 1);
        send_word(1'b1, 32'h4444, 16, 32, 1);
        idle(20);
        check("en_pending", exp_q.size(), 0);
        check("en_frames", rx_cnt - rx0, 1);
        check("en_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
